edge_pulse_generator: RTL and testbench



---
 rtl/edge_pulse_generator.sv | 192 +++++++++++++++++++
 tb/tb_edge_pulse_generator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_pulse_generator.sv
// ---------------------------------------------------------------------------
// edge_pulse_generator
//
// Purpose:
//   Converts single-cycle request strobes into a level waveform that a
//   downstream previous-cycle edge detector sees as exactly one rising edge
//   per request. Each accepted request produces HIGH_CYCLES cycles of wave=1
//   followed by at least GAP_CYCLES cycles of wave=0. Requests arriving while
//   a waveform is in progress are queued in a saturating counter and started
//   back to back, one waveform per HIGH_CYCLES+GAP_CYCLES cycles.
//
// Parameters:
//   HIGH_CYCLES  cycles wave is held high per request (>= 1)
//   GAP_CYCLES   minimum low cycles between two high intervals (>= 1)
//   PEND_WIDTH   width of the pending-request counter (capacity 2^W-1)
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   reset     in   synchronous active-high reset, clears all state
//   pulse     in   request strobe, each high cycle is one request
//   wave      out  generated level waveform (registered)
//   busy      out  high whenever the FSM is not idle (registered)
//   pending   out  queued requests not yet started (registered)
//   overflow  out  one-cycle flag after a request was dropped (registered)
// ---------------------------------------------------------------------------
module edge_pulse_generator #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pulse,
    output logic                  wave,
    output logic                  busy,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  overflow
);

    // The single down-counting timer serves both the high and the gap phase,
    // so it is sized for the longer of the two.
    localparam int TIMER_MAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0]    HIGH_LOAD = TIMER_W'(HIGH_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    TIMER_ONE = TIMER_W'(1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX  = '1;
    localparam logic [PEND_WIDTH-1:0] PEND_ONE  = PEND_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [TIMER_W-1:0]      timer_q;
    logic [TIMER_W-1:0]      timer_d;
    logic [PEND_WIDTH-1:0]   pending_q;
    logic [PEND_WIDTH-1:0]   pending_d;
    logic                    overflow_q;
    logic                    overflow_d;
    logic                    wave_q;
    logic                    busy_q;

    logic                    timer_done;
    logic                    queue_req;
    logic                    dequeue;

    // -----------------------------------------------------------------------
    // Pending-counter arithmetic.
    // push: a request arrived while a waveform is in progress.
    // pop : a queued request starts its high interval this cycle.
    // A push and a pop in the same cycle cancel out, which is also what lets
    // a request be accepted when the counter is full but one is leaving.
    // -----------------------------------------------------------------------
    function automatic logic [PEND_WIDTH-1:0] pend_next(
        input logic [PEND_WIDTH-1:0] cur,
        input logic                  push,
        input logic                  pop
    );
        logic [PEND_WIDTH-1:0] res;
        res = cur;
        case ({push, pop})
            2'b10:   res = (cur == PEND_MAX) ? cur : cur + PEND_ONE;
            2'b01:   res = cur - PEND_ONE;
            default: res = cur;
        endcase
        return res;
    endfunction

    // A request is dropped only when the counter is full and nothing leaves
    // the queue in the same cycle.
    function automatic logic pend_drop(
        input logic [PEND_WIDTH-1:0] cur,
        input logic                  push,
        input logic                  pop
    );
        return push && !pop && (cur == PEND_MAX);
    endfunction

    assign timer_done = (timer_q == '0);
    assign queue_req  = pulse && (state_q != ST_IDLE);

    // -----------------------------------------------------------------------
    // Next-state / counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dequeue = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A request in IDLE starts immediately; it never touches the
                // pending counter.
                if (pulse) begin
                    state_d = ST_HIGH;
                    timer_d = HIGH_LOAD;
                end
            end

            ST_HIGH: begin
                if (timer_done) begin
                    state_d = ST_GAP;
                    timer_d = GAP_LOAD;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            ST_GAP: begin
                if (timer_done) begin
                    // A request arriving in the last gap cycle with an empty
                    // queue is started directly: it is pushed and popped in
                    // the same cycle, so pending stays 0 and IDLE is never
                    // entered with a request still outstanding.
                    if ((pending_q != '0) || pulse) begin
                        state_d = ST_HIGH;
                        timer_d = HIGH_LOAD;
                        dequeue = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        pending_d  = pend_next(pending_q, queue_req, dequeue);
        overflow_d = pend_drop(pending_q, queue_req, dequeue);
    end

    // -----------------------------------------------------------------------
    // State and output registers.
    // wave/busy are decoded from the next state and registered, so the rise
    // of wave coincides with the state entering HIGH and no combinational
    // path from pulse reaches an output.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            wave_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            wave_q     <= (state_d == ST_HIGH);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign wave     = wave_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_edge_pulse_generator.sv
// ---------------------------------------------------------------------------
// tb_edge_pulse_generator
//
// Drives edge_pulse_generator with directed and random request patterns and
// compares every cycle against a timeline model: each accepted request is
// recorded with the cycle it was issued and the cycle its high interval
// starts, and wave/busy/pending/overflow are derived from those intervals.
// ---------------------------------------------------------------------------
module tb_edge_pulse_generator;

    localparam int H     = 4;
    localparam int G     = 2;
    localparam int PW    = 4;
    localparam int P     = H + G;
    localparam int MAXP  = (1 << PW) - 1;
    localparam int VW    = PW + 3;

    logic          clk;
    logic          reset;
    logic          pulse;
    logic          wave;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    logic [VW-1:0] act_v;
    logic [VW-1:0] exp_v;

    int n_cmp;
    int n_fail;
    int cyc;

    edge_pulse_generator #(
        .HIGH_CYCLES (H),
        .GAP_CYCLES  (G),
        .PEND_WIDTH  (PW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse    (pulse),
        .wave     (wave),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    assign act_v = {wave, busy, pending, overflow};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- timeline reference model ----------------
    typedef struct {
        int req;      // cycle the request strobe was high
        int s;        // first cycle wave is high for this request
        bit queued;   // request arrived while busy
    } ent_t;

    ent_t q[$];
    int   last_s;
    bit   ovf_flag;

    task automatic model_step(input int t, input bit p, input bit r);
        int pend;
        bit deq;
        bit drop;
        drop = 1'b0;
        if (r) begin
            q.delete();
            last_s   = -1000;
            ovf_flag = 1'b0;
        end else begin
            if (p) begin
                if (t >= last_s + P) begin
                    q.push_back('{t, t + 1, 1'b0});
                    last_s = t + 1;
                end else begin
                    pend = 0;
                    deq  = 1'b0;
                    foreach (q[i]) begin
                        if (q[i].queued && q[i].req < t && q[i].s > t) pend++;
                        if (q[i].queued && q[i].s == t + 1) deq = 1'b1;
                    end
                    if (pend == MAXP && !deq) begin
                        drop = 1'b1;
                    end else begin
                        q.push_back('{t, last_s + P, 1'b1});
                        last_s = last_s + P;
                    end
                end
            end
            ovf_flag = drop;
            while (q.size() > 0 && q[0].s + P < t) q.delete(0);
        end
    endtask

    task automatic model_expect(input int c, output logic [VW-1:0] v);
        logic ew;
        logic eb;
        int   ep;
        ew = 1'b0;
        eb = 1'b0;
        ep = 0;
        foreach (q[i]) begin
            if (c >= q[i].s && c <= q[i].s + H - 1) ew = 1'b1;
            if (c >= q[i].s && c <= q[i].s + P - 1) eb = 1'b1;
            if (q[i].queued && q[i].req < c && q[i].s > c) ep++;
        end
        v = {ew, eb, ep[PW-1:0], ovf_flag};
    endtask

    // Apply inputs for the current cycle, advance one clock, and compute the
    // expected outputs for the newly visible cycle (sampled on negedge).
    task automatic tick(input bit p, input bit r);
        pulse = p;
        reset = r;
        model_step(cyc, p, r);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        model_expect(cyc, exp_v);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        n_cmp++;
        if (act_v !== '0) begin
            n_fail++;
            $display("FAIL reset_state cyc=%0d got=%b want=%b", cyc, act_v, {VW{1'b0}});
        end
        for (int k = 1; k <= 8; k++) begin
            tick(1'b0, 1'b0);
            n_cmp++;
            if (act_v !== exp_v || wave !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_pulse_ignored cyc=%0d got=%b want=%b", cyc, act_v, exp_v);
            end
        end
    endtask

    task automatic test_single();
        logic [VW-1:0] want;
        do_reset();
        for (int k = 1; k <= P + 3; k++) begin
            tick(k == 1, 1'b0);
            want = {(k <= H) ? 1'b1 : 1'b0, (k <= P) ? 1'b1 : 1'b0, {PW{1'b0}}, 1'b0};
            n_cmp++;
            if (act_v !== want || act_v !== exp_v) begin
                n_fail++;
                $display("FAIL single k=%0d got=%b want=%b model=%b", k, act_v, want, exp_v);
            end
        end
    endtask

    task automatic test_two();
        logic [VW-1:0] want;
        logic          w;
        do_reset();
        for (int k = 1; k <= 2 * P + 2; k++) begin
            tick(k == 1 || k == 3, 1'b0);
            // issued at relative cycles 0 and 2; visible cycle k
            w    = ((k >= 1 && k <= H) || (k >= P + 1 && k <= P + H)) ? 1'b1 : 1'b0;
            want = {w, (k <= 2 * P) ? 1'b1 : 1'b0,
                    PW'((k >= 3 && k <= P) ? 1 : 0), 1'b0};
            n_cmp++;
            if (act_v !== want || act_v !== exp_v) begin
                n_fail++;
                $display("FAIL two_pulses k=%0d got=%b want=%b model=%b", k, act_v, want, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] want;
        logic          w;
        do_reset();
        // requests at relative 0, 2 and P (the dequeue cycle)
        for (int k = 1; k <= 3 * P + 2; k++) begin
            tick(k == 1 || k == 3 || k == P + 1, 1'b0);
            w = ((k >= 1 && k <= H) || (k >= P + 1 && k <= P + H) ||
                 (k >= 2 * P + 1 && k <= 2 * P + H)) ? 1'b1 : 1'b0;
            want = {w, (k <= 3 * P) ? 1'b1 : 1'b0,
                    PW'((k >= 3 && k <= 2 * P) ? 1 : 0), 1'b0};
            n_cmp++;
            if (act_v !== want || act_v !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back k=%0d got=%b want=%b model=%b", k, act_v, want, exp_v);
            end
        end
    endtask

    task automatic test_saturation();
        int ovf_seen;
        int ovf_want;
        do_reset();
        ovf_seen = 0;
        ovf_want = 0;
        for (int k = 1; k <= 40 + MAXP * P + 10; k++) begin
            tick(k <= 40, 1'b0);
            if (overflow === 1'b1) ovf_seen++;
            if (exp_v[0]) ovf_want++;
            n_cmp++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL saturation k=%0d got=%b want=%b", k, act_v, exp_v);
            end
        end
        n_cmp++;
        if (ovf_seen !== ovf_want || ovf_want == 0) begin
            n_fail++;
            $display("FAIL overflow_count got=%0d want=%0d", ovf_seen, ovf_want);
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] want;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        n_cmp++;
        if (act_v !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_clear got=%b want=%b", act_v, {VW{1'b0}});
        end
        for (int k = 1; k <= P + 2; k++) begin
            tick(k == 1, 1'b0);
            want = {(k <= H) ? 1'b1 : 1'b0, (k <= P) ? 1'b1 : 1'b0, {PW{1'b0}}, 1'b0};
            n_cmp++;
            if (act_v !== want || act_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid_restart k=%0d got=%b want=%b model=%b", k, act_v, want, exp_v);
            end
        end
    endtask

    task automatic test_random();
        int dens;
        bit p;
        bit r;
        do_reset();
        for (int k = 0; k < 900; k++) begin
            case ((k / 150) % 3)
                0:       dens = 12;
                1:       dens = 50;
                default: dens = 90;
            endcase
            p = ($urandom_range(99) < dens);
            r = ($urandom_range(299) == 0);
            tick(p, r);
            n_cmp++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL random k=%0d cyc=%0d got=%b want=%b", k, cyc, act_v, exp_v);
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        cyc      = 0;
        pulse    = 1'b0;
        reset    = 1'b1;
        last_s   = -1000;
        ovf_flag = 1'b0;
        test_reset();
        test_single();
        test_two();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
